// File: rtl/ictlb_fwd_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ictlb_fwd_arb_pkg
// Description : Shared types and address-slice constants for the ICTLB forward port.
// Revision    : 1.0 - initial release
// ============================================================================
package ictlb_fwd_arb_pkg;

    localparam int ICTLB_HPA_LSB = 12;
    localparam int ICTLB_HPA_MSB = 22;

    localparam int c_core_id_w = 5;
    localparam int c_laddr_w   = 39;
    localparam int c_hpa_w     = ICTLB_HPA_MSB - ICTLB_HPA_LSB + 1;
    localparam int c_ppa_w     = 3;

    typedef struct packed {
        logic [c_core_id_w-1:0] coreid;
        logic [c_laddr_w-1:0]   laddr;
    } I_coretoictlb_pc_type;

    typedef struct packed {
        logic [c_laddr_w-1:0] laddr;
        logic                 l2;
    } I_pfetol1tlb_req_type;

    typedef struct packed {
        logic [c_core_id_w-1:0] coreid;
        logic                   prefetch;
        logic                   fault;
        logic [c_hpa_w-1:0]     hpaadr;
        logic [c_ppa_w-1:0]     ppaadr;
    } I_l1tlbtol1_fwd_type;

    // Identity translation: the physical page bits are the linear page bits.
    function automatic I_l1tlbtol1_fwd_type ictlb_make_fwd(
        input logic [c_core_id_w-1:0] coreid,
        input logic                   prefetch,
        input logic [c_hpa_w-1:0]     hpa
    );
        I_l1tlbtol1_fwd_type f;
        f.coreid   = coreid;
        f.prefetch = prefetch;
        f.fault    = 1'b0;
        f.hpaadr   = hpa;
        f.ppaadr   = hpa[c_ppa_w-1:0];
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ictlb_fwd_arb_fflop.sv
`default_nettype none
// ============================================================================
// Module      : fflop
// Description : 2-entry registered FIFO; input retry is a pure function of occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module fflop #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_din_valid,
    output logic            o_din_retry,
    input  logic [SIZE-1:0] i_din,
    output logic            o_q_valid,
    input  logic            i_q_retry,
    output logic [SIZE-1:0] o_q
);

    logic [SIZE-1:0] r_mem [2];
    logic            r_rd_ptr;
    logic            r_wr_ptr;
    logic [1:0]      r_cnt;
    logic            w_enq;
    logic            w_deq;

    // Retry never looks at the output side, so a full buffer stalls even while draining.
    assign o_din_retry = (r_cnt == 2'd2);
    assign o_q_valid   = (r_cnt != 2'd0);
    assign o_q         = r_mem[r_rd_ptr];
    assign w_enq       = i_din_valid & ~o_din_retry;
    assign w_deq       = o_q_valid & ~i_q_retry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_enq) r_wr_ptr <= ~r_wr_ptr;
            if (w_deq) r_rd_ptr <= ~r_rd_ptr;
            case ({w_enq, w_deq})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_wr_ptr] <= i_din;
    end

endmodule
`default_nettype wire

// File: rtl/ictlb_fwd_arb.sv
`default_nettype none
// ============================================================================
// Module      : ictlb_fwd_arb
// Description : Core/prefetch arbiter for the ICTLB forward port with bounded prefetch starvation.
// Revision    : 1.0 - initial release
// ============================================================================
module ictlb_fwd_arb
    import ictlb_fwd_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 coretoictlb_pc_valid,
    output logic                 coretoictlb_pc_retry,
    input  I_coretoictlb_pc_type coretoictlb_pc,
    input  logic                 pfetol1tlb_req_valid,
    output logic                 pfetol1tlb_req_retry,
    input  I_pfetol1tlb_req_type pfetol1tlb_req,
    output logic                 l1tlbtol1_fwd_valid,
    input  logic                 l1tlbtol1_fwd_retry,
    output I_l1tlbtol1_fwd_type  l1tlbtol1_fwd
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    logic                r_starve_cnt_unused_guard;
    logic [3:0]          r_starve_cnt;
    logic [3:0]          w_starve_nxt;
    logic                w_full;
    logic                w_pf_elig;
    logic                w_force;
    logic                w_grant_pf;
    logic                w_grant_core;
    logic [c_hpa_w-1:0]  w_core_hpa;
    logic [c_hpa_w-1:0]  w_pf_hpa;
    I_l1tlbtol1_fwd_type w_enq_data;
    logic                w_unused;

    assign w_pf_elig    = pfetol1tlb_req_valid & ~pfetol1tlb_req.l2;
    assign w_force      = (r_starve_cnt == c_starve_limit);
    assign w_grant_pf   = w_pf_elig & ~w_full & (w_force | ~coretoictlb_pc_valid);
    assign w_grant_core = coretoictlb_pc_valid & ~w_full & ~w_grant_pf;

    // An l2 prefetch is never retried: it is swallowed without being forwarded.
    assign coretoictlb_pc_retry = w_full | w_grant_pf;
    assign pfetol1tlb_req_retry = w_pf_elig & ~w_grant_pf;

    assign w_core_hpa = coretoictlb_pc.laddr[ICTLB_HPA_MSB:ICTLB_HPA_LSB];
    assign w_pf_hpa   = pfetol1tlb_req.laddr[ICTLB_HPA_MSB:ICTLB_HPA_LSB];
    assign w_enq_data = w_grant_pf ? ictlb_make_fwd('0, 1'b1, w_pf_hpa)
                                   : ictlb_make_fwd(coretoictlb_pc.coreid, 1'b0, w_core_hpa);

    assign w_unused = ^{coretoictlb_pc.laddr[c_laddr_w-1:ICTLB_HPA_MSB+1],
                        coretoictlb_pc.laddr[ICTLB_HPA_LSB-1:0],
                        pfetol1tlb_req.laddr[c_laddr_w-1:ICTLB_HPA_MSB+1],
                        pfetol1tlb_req.laddr[ICTLB_HPA_LSB-1:0],
                        r_starve_cnt_unused_guard};
    assign r_starve_cnt_unused_guard = 1'b0;

    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (w_grant_pf || !w_pf_elig) begin
            w_starve_nxt = 4'd0;
        end else if (w_grant_core && (r_starve_cnt != c_starve_limit)) begin
            w_starve_nxt = r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= 4'd0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
        end
    end

    fflop #(
        .SIZE($bits(I_l1tlbtol1_fwd_type))
    ) u_fflop (
        .clk         (clk),
        .rst         (reset),
        .i_din_valid (w_grant_pf | w_grant_core),
        .o_din_retry (w_full),
        .i_din       (w_enq_data),
        .o_q_valid   (l1tlbtol1_fwd_valid),
        .i_q_retry   (l1tlbtol1_fwd_retry),
        .o_q         (l1tlbtol1_fwd)
    );

endmodule
`default_nettype wire

// File: tb/tb_ictlb_fwd_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ictlb_fwd_arb
// Description : Scoreboard bench for ictlb_fwd_arb using hand-computed directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ictlb_fwd_arb;
    import ictlb_fwd_arb_pkg::*;

    logic                 clk;
    logic                 reset;
    logic                 core_valid;
    logic                 core_retry;
    I_coretoictlb_pc_type core_pc;
    logic                 pf_valid;
    logic                 pf_retry;
    I_pfetol1tlb_req_type pf_req;
    logic                 fwd_valid;
    logic                 fwd_retry;
    I_l1tlbtol1_fwd_type  fwd;

    I_l1tlbtol1_fwd_type  sb[$];
    int                   n_cmp = 0;
    int                   n_err = 0;

    ictlb_fwd_arb #(.STARVE_LIMIT(4)) dut (
        .clk                  (clk),
        .reset                (reset),
        .coretoictlb_pc_valid (core_valid),
        .coretoictlb_pc_retry (core_retry),
        .coretoictlb_pc       (core_pc),
        .pfetol1tlb_req_valid (pf_valid),
        .pfetol1tlb_req_retry (pf_retry),
        .pfetol1tlb_req       (pf_req),
        .l1tlbtol1_fwd_valid  (fwd_valid),
        .l1tlbtol1_fwd_retry  (fwd_retry),
        .l1tlbtol1_fwd        (fwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic I_l1tlbtol1_fwd_type exp_fwd(input logic [4:0] cid, input logic pfb,
                                                    input logic [38:0] laddr);
        I_l1tlbtol1_fwd_type e;
        e.coreid   = pfb ? 5'd0 : cid;
        e.prefetch = pfb;
        e.fault    = 1'b0;
        e.hpaadr   = laddr[22:12];
        e.ppaadr   = laddr[14:12];
        return e;
    endfunction

    function automatic logic [38:0] caddr(input int i);
        return 39'h0010_0000 + 39'(i) * 39'h1000;
    endfunction

    function automatic logic [38:0] paddr(input int i);
        return 39'h0070_0000 + 39'(i) * 39'h1000;
    endfunction

    // Monitor: every transfer on the forward port must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && fwd_valid && !fwd_retry) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL fwd_unexpected: got coreid=%0d pf=%b hpa=%h, want no transfer",
                         fwd.coreid, fwd.prefetch, fwd.hpaadr);
            end else begin
                I_l1tlbtol1_fwd_type e;
                e = sb.pop_front();
                if (fwd !== e) begin
                    n_err++;
                    $display("FAIL fwd_payload: got coreid=%0d pf=%b flt=%b hpa=%h ppa=%h, want coreid=%0d pf=%b flt=%b hpa=%h ppa=%h",
                             fwd.coreid, fwd.prefetch, fwd.fault, fwd.hpaadr, fwd.ppaadr,
                             e.coreid, e.prefetch, e.fault, e.hpaadr, e.ppaadr);
                end
            end
        end
    end

    task automatic check_bit(input string name, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end
    endtask

    task automatic check_empty(input string name);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d expected transfers never seen, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    // One cycle of stimulus; the expected grant follows from the hand-computed retries.
    task automatic cyc(input logic cv, input logic [4:0] cid, input logic [38:0] ca,
                       input logic pv, input logic [38:0] pa, input logic pl2,
                       input logic dret, input logic exp_cret, input logic exp_pret,
                       input string tag);
        core_valid     = cv;
        core_pc.coreid = cid;
        core_pc.laddr  = ca;
        pf_valid       = pv;
        pf_req.laddr   = pa;
        pf_req.l2      = pl2;
        fwd_retry      = dret;
        @(negedge clk);
        n_cmp++;
        if ({core_retry, pf_retry} !== {exp_cret, exp_pret}) begin
            n_err++;
            $display("FAIL %s_retry: got core=%b pf=%b, want core=%b pf=%b",
                     tag, core_retry, pf_retry, exp_cret, exp_pret);
        end
        @(posedge clk);
        if (pv && !pl2 && !exp_pret) sb.push_back(exp_fwd(5'd0, 1'b1, pa));
        else if (cv && !exp_cret)    sb.push_back(exp_fwd(cid, 1'b0, ca));
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 5'd0, '0, 0, '0, 0, 0, 0, 0, "idle");
    endtask

    // Both requesters continuously valid: four core grants, then one prefetch grant.
    task automatic starve_run(input int cycles, input logic [4:0] cid, input int cbase,
                              input int pbase, input string tag);
        int ci = cbase;
        int pi = pbase;
        for (int k = 0; k < cycles; k++) begin
            logic pfg;
            pfg = ((k % 5) == 4);
            cyc(1, cid, caddr(ci), 1, paddr(pi), 0, 0, pfg, !pfg, tag);
            if (pfg) pi++;
            else     ci++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        core_valid = 1'b0;
        core_pc    = '0;
        pf_valid   = 1'b0;
        pf_req     = '0;
        fwd_retry  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_bit("reset_fwd_valid", fwd_valid, 1'b0);
        reset = 1'b0;
        #1;
        check_bit("idle_core_retry", core_retry, 1'b0);
        check_bit("idle_pf_retry", pf_retry, 1'b0);
        check_bit("idle_fwd_valid", fwd_valid, 1'b0);

        // Core only, back to back
        cyc(1, 5'd1, 39'h0040_3000, 0, '0, 0, 0, 0, 0, "core");
        cyc(1, 5'd1, 39'h0040_4000, 0, '0, 0, 0, 0, 0, "core");
        cyc(1, 5'd1, 39'h0040_5000, 0, '0, 0, 0, 0, 0, "core");
        idle(3);
        check_empty("core_drain");

        // l2 prefetch is consumed without forwarding
        for (int i = 0; i < 5; i++) begin
            cyc(0, 5'd0, '0, 1, 39'h0012_3000, 1, 0, 0, 0, "l2drop");
            check_bit("l2drop_fwd_valid", fwd_valid, 1'b0);
        end
        idle(1);
        check_empty("l2drop_drain");

        // Starvation: 4:1 pattern, twice
        starve_run(10, 5'd3, 0, 0, "starve");
        idle(3);
        check_empty("starve_drain");

        // Backpressure: two accepted, then core held
        cyc(1, 5'd2, caddr(20), 0, '0, 0, 1, 0, 0, "bp");
        cyc(1, 5'd2, caddr(21), 0, '0, 0, 1, 0, 0, "bp");
        for (int i = 0; i < 4; i++) cyc(1, 5'd2, caddr(22), 0, '0, 0, 1, 1, 0, "bp_full");
        check_bit("bp_fwd_valid_held", fwd_valid, 1'b1);
        cyc(1, 5'd2, caddr(22), 0, '0, 0, 0, 1, 0, "bp_release");
        cyc(1, 5'd2, caddr(22), 0, '0, 0, 0, 0, 0, "bp_third");
        idle(3);
        check_empty("bp_drain");

        // Async reset with two buffered entries and a partly advanced starve counter
        cyc(1, 5'd4, caddr(30), 1, paddr(30), 0, 1, 0, 1, "rst_pre");
        cyc(1, 5'd4, caddr(31), 1, paddr(30), 0, 1, 0, 1, "rst_pre");
        cyc(1, 5'd4, caddr(32), 1, paddr(30), 0, 1, 1, 1, "rst_full");
        check_bit("rst_fwd_valid_before", fwd_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_bit("rst_fwd_valid_async", fwd_valid, 1'b0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        starve_run(5, 5'd4, 32, 30, "rst_post");
        idle(3);
        check_empty("rst_drain");

        // Prefetch alone is granted every cycle and leaves the counter at zero
        for (int i = 0; i < 3; i++) cyc(0, 5'd0, '0, 1, paddr(40 + i), 0, 0, 1, 0, "pf_only");
        starve_run(5, 5'd6, 50, 43, "pf_then_both");
        idle(3);
        check_empty("pf_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
